// File: rtl/windowed_register_file_if.sv
// rtl/windowed_register_file_if.sv - operand/writeback/window-control bundle for windowed_register_file
interface windowed_register_file_if #(
   parameter int NWINDOWS = 4,
   parameter int CWPW     = 2
);
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [4:0]          rd;
   logic                we;
   logic [31:0]         wr_data;
   logic                save;
   logic                restore;
   logic                cwp_we;
   logic [CWPW-1:0]     cwp_in;
   logic                wim_we;
   logic [NWINDOWS-1:0] wim_in;
   logic [31:0]         rdata1;
   logic [31:0]         rdata2;
   logic [CWPW-1:0]     cwp;
   logic [NWINDOWS-1:0] wim;
   logic                window_overflow;
   logic                window_underflow;

   modport master (
      output rs1, rs2, rd, we, wr_data, save, restore, cwp_we, cwp_in, wim_we, wim_in,
      input  rdata1, rdata2, cwp, wim, window_overflow, window_underflow
   );

   modport slave (
      input  rs1, rs2, rd, we, wr_data, save, restore, cwp_we, cwp_in, wim_we, wim_in,
      output rdata1, rdata2, cwp, wim, window_overflow, window_underflow
   );
endinterface

// File: rtl/windowed_register_file.sv
// rtl/windowed_register_file.sv - SPARC V8 windowed integer register file with CWP/WIM and window traps
module windowed_register_file #(
   parameter int NWINDOWS = 4,
   parameter int CWPW     = 2
) (
   input logic                    clk,
   input logic                    reset_n,
   windowed_register_file_if.slave bus
);
   localparam int NPHYS = 16 * NWINDOWS;
   localparam int IW    = CWPW + 4;

   logic [31:0]         gregs [8];
   logic [31:0]         wregs [NPHYS];
   logic [CWPW-1:0]     cwp_q;
   logic [NWINDOWS-1:0] wim_q;
   logic                ovf_q;
   logic                unf_q;

   logic [CWPW-1:0]     save_tgt;
   logic [CWPW-1:0]     rest_tgt;
   logic [CWPW-1:0]     cwp_nx;
   logic                ovf_nx;
   logic                unf_nx;
   logic                wr_en;

   // Ins of window c live in the outs slot of window c+1; CWPW-bit wrap gives the mod.
   function automatic logic [IW-1:0] widx(input logic [4:0] r, input logic [CWPW-1:0] c);
      case (r[4:3])
         2'b01:   widx = {c, 1'b0, r[2:0]};
         2'b10:   widx = {c, 1'b1, r[2:0]};
         default: widx = {c + CWPW'(1), 1'b0, r[2:0]};
      endcase
   endfunction

   function automatic logic [31:0] read_reg(input logic [4:0] r, input logic [CWPW-1:0] c);
      if (r == 5'd0)
         read_reg = 32'd0;
      else if (r[4:3] == 2'b00)
         read_reg = gregs[r[2:0]];
      else
         read_reg = wregs[widx(r, c)];
   endfunction

   always_comb begin
      bus.rdata1 = read_reg(bus.rs1, cwp_q);
      bus.rdata2 = read_reg(bus.rs2, cwp_q);
   end

   // Trap checks use the pre-edge WIM; a trapped SAVE/RESTORE also kills the writeback.
   always_comb begin
      save_tgt = cwp_q - CWPW'(1);
      rest_tgt = cwp_q + CWPW'(1);
      cwp_nx   = cwp_q;
      ovf_nx   = 1'b0;
      unf_nx   = 1'b0;
      if (bus.cwp_we) begin
         cwp_nx = bus.cwp_in;
      end else if (bus.save && !bus.restore) begin
         if (wim_q[save_tgt]) ovf_nx = 1'b1;
         else                 cwp_nx = save_tgt;
      end else if (bus.restore && !bus.save) begin
         if (wim_q[rest_tgt]) unf_nx = 1'b1;
         else                 cwp_nx = rest_tgt;
      end
      wr_en = bus.we && (bus.rd != 5'd0) && !ovf_nx && !unf_nx;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 8; i++)     gregs[i] <= 32'd0;
         for (int i = 0; i < NPHYS; i++) wregs[i] <= 32'd0;
         cwp_q <= '0;
         wim_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         cwp_q <= cwp_nx;
         ovf_q <= ovf_nx;
         unf_q <= unf_nx;
         if (bus.wim_we) wim_q <= bus.wim_in;
         if (wr_en) begin
            if (bus.rd[4:3] == 2'b00) gregs[bus.rd[2:0]]     <= bus.wr_data;
            else                      wregs[widx(bus.rd, cwp_nx)] <= bus.wr_data;
         end
      end
   end

   assign bus.cwp              = cwp_q;
   assign bus.wim              = wim_q;
   assign bus.window_overflow  = ovf_q;
   assign bus.window_underflow = unf_q;
endmodule

// File: tb/tb_windowed_register_file.sv
// tb/tb_windowed_register_file.sv - directed scoreboard bench for windowed_register_file
module tb_windowed_register_file;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   logic [31:0] exp_q [$];

   always #5 clk = ~clk;

   windowed_register_file_if #(.NWINDOWS(4), .CWPW(2)) bus ();

   windowed_register_file #(.NWINDOWS(4), .CWPW(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic push(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic idle();
      bus.we = 1'b0; bus.rd = 5'd0; bus.wr_data = 32'd0;
      bus.save = 1'b0; bus.restore = 1'b0;
      bus.cwp_we = 1'b0; bus.cwp_in = 2'd0;
      bus.wim_we = 1'b0; bus.wim_in = 4'd0;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      idle();
   endtask

   task automatic wr(input logic [4:0] r, input logic [31:0] d);
      bus.we = 1'b1; bus.rd = r; bus.wr_data = d;
   endtask

   task automatic rd1(input logic [4:0] r);
      bus.rs1 = r;
      #1;
   endtask

   initial begin
      idle();
      bus.rs1 = 5'd1; bus.rs2 = 5'd8;
      #12;
      push(32'd0); chk("reset_cwp", 32'(bus.cwp));
      push(32'd0); chk("reset_wim", 32'(bus.wim));
      push(32'd0); chk("reset_rdata1", bus.rdata1);
      push(32'd0); chk("reset_ovf", 32'(bus.window_overflow));
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #2;

      // Globals and r0
      wr(5'd1, 32'h12345678); tick();
      wr(5'd0, 32'hFFFFFFFF); tick();
      bus.rs2 = 5'd0; rd1(5'd1);
      push(32'h12345678); chk("t1_r1", bus.rdata1);
      push(32'h00000000); chk("t1_r0", bus.rdata2);
      wr(5'd2, 32'h55); rd1(5'd2);
      push(32'd0); chk("no_bypass", bus.rdata1);
      tick(); rd1(5'd2);
      push(32'h55); chk("write_visible", bus.rdata1);

      // Outs become ins of the next window after SAVE
      wr(5'd8, 32'hA5A5A5A5); tick();
      bus.save = 1'b1; tick();
      push(32'd3); chk("t2_save_wrap", 32'(bus.cwp));
      rd1(5'd24);
      push(32'hA5A5A5A5); chk("t2_ins_overlap", bus.rdata1);
      bus.restore = 1'b1; tick();
      push(32'd0); chk("t2_restore_wrap", 32'(bus.cwp));
      rd1(5'd8);
      push(32'hA5A5A5A5); chk("t2_outs_kept", bus.rdata1);

      // Locals isolation; write alongside SAVE goes to the new window
      wr(5'd16, 32'h1); tick();
      bus.save = 1'b1; wr(5'd16, 32'h2); tick();
      rd1(5'd16);
      push(32'h2); chk("t5_local_w3", bus.rdata1);
      rd1(5'd1);
      push(32'h12345678); chk("t5_global_w3", bus.rdata1);
      bus.restore = 1'b1; tick();
      rd1(5'd16);
      push(32'h1); chk("t5_local_w0", bus.rdata1);

      // Overflow trap, write suppression, back-to-back pulses
      bus.wim_we = 1'b1; bus.wim_in = 4'b0010; bus.cwp_we = 1'b1; bus.cwp_in = 2'd2; tick();
      push(32'h2); chk("t3_wim", 32'(bus.wim));
      bus.save = 1'b1; wr(5'd16, 32'hDEAD); tick();
      push(32'd2); chk("t3_cwp_held", 32'(bus.cwp));
      push(32'd1); chk("t3_ovf", 32'(bus.window_overflow));
      rd1(5'd16);
      push(32'd0); chk("t3_write_suppressed", bus.rdata1);
      bus.save = 1'b1; tick();
      push(32'd1); chk("t3_ovf_b2b", 32'(bus.window_overflow));
      tick();
      push(32'd0); chk("t3_ovf_cleared", 32'(bus.window_overflow));

      // Underflow trap; same-edge WIM write does not affect the check
      bus.cwp_we = 1'b1; bus.cwp_in = 2'd0; tick();
      bus.restore = 1'b1; tick();
      push(32'd0); chk("t4_cwp_held", 32'(bus.cwp));
      push(32'd1); chk("t4_unf", 32'(bus.window_underflow));
      push(32'd0); chk("t4_no_ovf", 32'(bus.window_overflow));
      bus.restore = 1'b1; bus.wim_we = 1'b1; bus.wim_in = 4'b0000; tick();
      push(32'd1); chk("t4_old_wim_unf", 32'(bus.window_underflow));
      push(32'd0); chk("t4_wim_cleared", 32'(bus.wim));
      bus.restore = 1'b1; tick();
      push(32'd1); chk("t4_restore_ok", 32'(bus.cwp));
      push(32'd0); chk("t4_unf_clear", 32'(bus.window_underflow));

      // cwp_we beats SAVE; write lands in cwp_in window
      bus.cwp_we = 1'b1; bus.cwp_in = 2'd3; bus.save = 1'b1; wr(5'd17, 32'h77); tick();
      push(32'd3); chk("prio_cwp_we", 32'(bus.cwp));
      push(32'd0); chk("prio_no_trap", 32'(bus.window_overflow));
      rd1(5'd17);
      push(32'h77); chk("prio_write_win", bus.rdata1);

      // Async reset mid-sequence
      bus.wim_we = 1'b1; bus.wim_in = 4'b1000; tick();
      push(32'h8); chk("t6_wim_pre", 32'(bus.wim));
      bus.rs1 = 5'd1; bus.rs2 = 5'd8; bus.save = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      push(32'd0); chk("t6_rst_cwp", 32'(bus.cwp));
      push(32'd0); chk("t6_rst_wim", 32'(bus.wim));
      push(32'd0); chk("t6_rst_rdata1", bus.rdata1);
      push(32'd0); chk("t6_rst_rdata2", bus.rdata2);
      @(posedge clk); #2;
      push(32'd0); chk("t6_save_discarded", 32'(bus.cwp));
      @(negedge clk); reset_n = 1'b1; idle();
      @(posedge clk); #2;

      // save+restore together: ignored, write uses current window
      bus.save = 1'b1; bus.restore = 1'b1; wr(5'd16, 32'h99); tick();
      push(32'd0); chk("both_cwp", 32'(bus.cwp));
      push(32'd0); chk("both_no_ovf", 32'(bus.window_overflow));
      push(32'd0); chk("both_no_unf", 32'(bus.window_underflow));
      rd1(5'd16);
      push(32'h99); chk("both_write_cur", bus.rdata1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
